viterbi_frame_ctrl: RTL
=======================

VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 Parameter: TB_LEN, default 32, the decoder traceback length (>=2), which must equal the TB_LEN of the attached viterbi_decoder_7_5.
REQ-002 Parameter: LEN_W, default 16, the width of the frame-length field.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle frame request; sampled only in IDLE.
REQ-006 frame_len  input  LEN_W  info-bit count N (excluding the 2 tail bits); sampled with start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse on the transition DRAIN->IDLE.
REQ-009 in_valid / in_ready / in_sym  input 1 / output 1 / input 2  received symbol stream {v1,v0}; transfer when valid&ready.
REQ-010 out_valid / out_ready / out_bit / out_last  output 1 / input 1 / output 1 / output 1  decoded info-bit stream; out_last marks bit N-1.
REQ-011 dec_rst / dec_sym_valid / dec_rx_sym  output 1 / output 1 / output 2  drive the decoder's rst, sym_valid and rx_sym; all registered.
REQ-012 dec_bit_valid / dec_bit_out  input 1 / input 1  connect to the decoder's bit_valid and bit_out.

Function
REQ-013 FSM states: IDLE, CLEAR, DATA, FLUSH, DRAIN.
REQ-014 IDLE: on start with frame_len!=0, latch N and go to CLEAR; start with frame_len==0 is ignored; start outside IDLE is ignored.
REQ-015 CLEAR: dec_rst=1 for exactly one cycle, then go to DATA.
REQ-016 DATA: accept exactly N+2 symbols from in_*, then go to FLUSH; in_ready=0 in all other states.
REQ-017 FLUSH: issue exactly TB_LEN-1 symbols with value 2'b00, then go to DRAIN.
REQ-018 DRAIN: wait until the outstanding count is 0 and the FIFO is empty, then go to IDLE with a done pulse.
REQ-019 Symbol issue: each accepted or flush symbol drives dec_sym_valid=1 with dec_rx_sym=value on the next cycle; otherwise dec_sym_valid=0.
REQ-020 Capture: the decoder result of an issued symbol is sampled 2 cycles after acceptance, i.e. 1 cycle after dec_sym_valid.
REQ-021 Capture filter: the sampled bit is kept only if dec_bit_valid=1; kept bits are indexed k=0,1,2,... per frame.
REQ-022 Forwarding: kept bits with k<N are written to the output FIFO; bits k=N and k=N+1 (tail) are discarded.
REQ-023 Count check: total kept bits per frame = N+2.
REQ-024 Output FIFO: depth 4, first-word fall-through; out_valid = not empty; an entry pops when out_valid&out_ready.
REQ-025 out_last=1 exactly with the entry for k=N-1.
REQ-026 Credit: the outstanding count is issued symbols whose capture cycle has not passed (0..2).
REQ-027 Credit gate: a symbol (input or flush) may issue only if FIFO occupancy + outstanding < 4, counting a same-cycle pop.
REQ-028 Throughput: with out_ready=1 and in_valid=1, one symbol issues per cycle.
REQ-029 Backpressure: out_ready=0 stalls symbol issue; no bit is lost or duplicated.
REQ-030 Counter widths: symbol and bit counters are LEN_W+1 bits; N up to 2^LEN_W-1 works without wrap.
REQ-031 Simultaneous FIFO push and pop leaves occupancy unchanged.

Reset
REQ-032 On rst: state=IDLE; busy=0, done=0, in_ready=0, out_valid=0, out_bit=0, out_last=0, dec_sym_valid=0, dec_rx_sym=0, dec_rst=1.
REQ-033 Reset clears the FIFO, the counters and the outstanding count.
REQ-034 rst mid-frame aborts the frame with no done pulse; the first start after rst deasserts is honoured.

Verification (TB_LEN=8, LEN_W=16, decoder attached)
REQ-035 N=4, symbols 11,10,00,01,01,11, out_ready=1 -> out_bit 1,0,1,1; out_last on 4th; done pulse; exactly 7 flush symbols of 00 issued.
REQ-036 Same frame, one symbol flipped (10 at index 2) -> output still 1,0,1,1.
REQ-037 Same frame, out_ready toggled 1-in-3 -> identical output; FIFO never exceeds 4 entries; no dec_sym_valid while credit is exhausted.
REQ-038 start with frame_len=0, and start while busy -> ignored; busy unchanged; no dec_sym_valid.
REQ-039 rst asserted after the 3rd DATA symbol, then a new N=4 frame -> only the 4 bits of the new frame are output, plus one done pulse.
REQ-040 Back-to-back frames (start on the cycle after done) -> dec_rst pulses once per frame; outputs are correct for both frames.

Source files
------------

// File: rtl/viterbi_frame_ctrl.sv
// Frame controller for a rate-1/2 (7,5) Viterbi decoder: clears the decoder,
// streams N+2 symbols plus a zero flush, and collects N decoded bits in a small FIFO.
module viterbi_frame_ctrl #(
    parameter int TB_LEN = 32,
    parameter int LEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             dec_rst,
    output logic             dec_sym_valid,
    output logic [1:0]       dec_rx_sym,
    input  logic             dec_bit_valid,
    input  logic             dec_bit_out
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [LEN_W:0] CNT_ZERO   = {(LEN_W+1){1'b0}};
    localparam logic [LEN_W:0] CNT_ONE    = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] FLUSH_LAST = (LEN_W+1)'(TB_LEN - 2);

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [LEN_W-1:0] n_r;
    logic [LEN_W:0]   n_ext_s;
    logic [LEN_W:0]   sym_cnt_r;
    logic [LEN_W:0]   bit_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             dec_rst_r;
    logic             dec_sym_valid_r;
    logic [1:0]       dec_rx_sym_r;
    logic             cap_pend_r;

    logic             fifo_bit_r  [0:3];
    logic             fifo_last_r [0:3];
    logic [2:0]       fifo_cnt_r;
    logic [2:0]       fifo_cnt_next_s;
    logic             out_valid_r;

    logic             pop_s;
    logic [3:0]       load_s;
    logic             credit_ok_s;
    logic             in_ready_s;
    logic             data_issue_s;
    logic             flush_issue_s;
    logic             capture_s;
    logic             push_s;
    logic             push_last_s;
    logic [1:0]       push_idx_s;

    // Credit, issue and FIFO bookkeeping; the load term counts FIFO entries plus
    // symbols still in the decoder pipe, less an entry leaving this cycle.
    always_comb begin
        n_ext_s         = {1'b0, n_r};
        pop_s           = out_valid_r & out_ready;
        load_s          = {1'b0, fifo_cnt_r} + {3'b000, dec_sym_valid_r}
                        + {3'b000, cap_pend_r} - {3'b000, pop_s};
        credit_ok_s     = (load_s < 4'd4);
        in_ready_s      = ~rst & (state_r == ST_DATA) & credit_ok_s;
        data_issue_s    = in_ready_s & in_valid;
        flush_issue_s   = ~rst & (state_r == ST_FLUSH) & credit_ok_s;
        capture_s       = cap_pend_r & dec_bit_valid;
        push_s          = capture_s & (bit_cnt_r < n_ext_s);
        push_last_s     = (bit_cnt_r == (n_ext_s - CNT_ONE));
        push_idx_s      = fifo_cnt_r[1:0] - {1'b0, pop_s};
        fifo_cnt_next_s = fifo_cnt_r + {2'b00, push_s} - {2'b00, pop_s};
    end

    // Next-state logic of the frame sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (frame_len != {LEN_W{1'b0}})) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_s = ST_DATA;
            ST_DATA: begin
                if (data_issue_s && (sym_cnt_r == (n_ext_s + CNT_ONE))) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_FLUSH: begin
                if (flush_issue_s && (sym_cnt_r == FLUSH_LAST)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (!dec_sym_valid_r && !cap_pend_r && (fifo_cnt_r == 3'd0)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state, frame length, symbol/bit counters and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            n_r       <= {LEN_W{1'b0}};
            sym_cnt_r <= CNT_ZERO;
            bit_cnt_r <= CNT_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dec_rst_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_r == ST_DRAIN) && (state_s == ST_IDLE);
            dec_rst_r <= (state_s == ST_CLEAR);
            if ((state_r == ST_IDLE) && (state_s == ST_CLEAR)) begin
                n_r <= frame_len;
            end
            // The symbol counter is shared: data symbols first, then flush symbols.
            if (state_r == ST_CLEAR) begin
                sym_cnt_r <= CNT_ZERO;
            end else if (data_issue_s && (state_s == ST_FLUSH)) begin
                sym_cnt_r <= CNT_ZERO;
            end else if (data_issue_s || flush_issue_s) begin
                sym_cnt_r <= sym_cnt_r + CNT_ONE;
            end
            if (state_r == ST_CLEAR) begin
                bit_cnt_r <= CNT_ZERO;
            end else if (capture_s) begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
        end
    end

    // Symbol issue to the decoder and the one-cycle-later capture marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_sym_valid_r <= 1'b0;
            dec_rx_sym_r    <= 2'b00;
            cap_pend_r      <= 1'b0;
        end else begin
            dec_sym_valid_r <= data_issue_s | flush_issue_s;
            dec_rx_sym_r    <= data_issue_s ? in_sym : 2'b00;
            cap_pend_r      <= dec_sym_valid_r;
        end
    end

    // Shift-register output FIFO; entry 0 is always the head so outputs come from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_bit_r[i]  <= 1'b0;
                fifo_last_r[i] <= 1'b0;
            end
            fifo_cnt_r  <= 3'd0;
            out_valid_r <= 1'b0;
        end else begin
            if (pop_s) begin
                for (int i = 0; i < 3; i++) begin
                    fifo_bit_r[i]  <= fifo_bit_r[i+1];
                    fifo_last_r[i] <= fifo_last_r[i+1];
                end
                fifo_bit_r[3]  <= 1'b0;
                fifo_last_r[3] <= 1'b0;
            end
            if (push_s) begin
                fifo_bit_r[push_idx_s]  <= dec_bit_out;
                fifo_last_r[push_idx_s] <= push_last_s;
            end
            fifo_cnt_r  <= fifo_cnt_next_s;
            out_valid_r <= (fifo_cnt_next_s != 3'd0);
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_r;
    assign out_bit       = fifo_bit_r[0];
    assign out_last      = fifo_last_r[0];
    assign dec_rst       = dec_rst_r;
    assign dec_sym_valid = dec_sym_valid_r;
    assign dec_rx_sym    = dec_rx_sym_r;

endmodule
